// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register for a PC/instruction pair, with flush-to-bubble
// and an optional one-entry skid buffer that keeps in_ready registered.
module pipe_stage_reg #(
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}},
  parameter bit                 SKID      = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  localparam logic [ADDR_W-1:0] PC_ZERO = {ADDR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               in_ready_s;
  logic               accept_s;
  logic               emit_s;

  // Without the skid entry the stage can only take a beat when its single slot frees up.
  assign in_ready_s = SKID ? in_ready_q : (!out_valid_q || out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign emit_s     = out_valid_q && out_ready;

  // Next-state and datapath selection; flush overrides every handshake.
  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      state_d      = ST_EMPTY;
      main_pc_d    = PC_ZERO;
      main_instr_d = NOP_INSTR;
      skid_pc_d    = PC_ZERO;
      skid_instr_d = NOP_INSTR;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d      = ST_ONE;
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && emit_s) begin
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
          end else if (accept_s && SKID) begin
            state_d      = ST_TWO;
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
          end else if (emit_s) begin
            state_d      = ST_EMPTY;
            main_pc_d    = PC_ZERO;
            main_instr_d = NOP_INSTR;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (emit_s) begin
            state_d      = ST_ONE;
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            skid_pc_d    = PC_ZERO;
            skid_instr_d = NOP_INSTR;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d      = ST_EMPTY;
          main_pc_d    = PC_ZERO;
          main_instr_d = NOP_INSTR;
          skid_pc_d    = PC_ZERO;
          skid_instr_d = NOP_INSTR;
        end
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  // State, payload and registered handshake flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_EMPTY;
      main_pc_q    <= PC_ZERO;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= PC_ZERO;
      skid_instr_q <= NOP_INSTR;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_pc    = main_pc_q;
  assign out_instr = main_instr_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1 instance and a SKID=0 instance
// share clock and reset; expected values are hand-computed per step.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  int          n_tests;
  int          n_fail;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_in_pc, a_in_instr, a_out_pc, a_out_instr;
  logic [1:0]  a_occupancy;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [31:0] b_in_pc, b_in_instr, b_out_pc, b_out_instr;
  logic [1:0]  b_occupancy;

  pipe_stage_reg #(.INSTR_W(32), .ADDR_W(32), .NOP_INSTR(NOP), .SKID(1'b1)) u_skid (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_pc(a_in_pc), .in_instr(a_in_instr),
    .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
    .out_instr(a_out_instr), .occupancy(a_occupancy)
  );

  pipe_stage_reg #(.INSTR_W(32), .ADDR_W(32), .NOP_INSTR(NOP), .SKID(1'b0)) u_noskid (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_pc(b_in_pc), .in_instr(b_in_instr),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
    .out_instr(b_out_instr), .occupancy(b_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [1:0] occ, input logic rdy);
    check_eq({tag, "_valid"}, {31'd0, a_out_valid}, {31'd0, v});
    check_eq({tag, "_pc"}, a_out_pc, pc);
    check_eq({tag, "_instr"}, a_out_instr, ins);
    check_eq({tag, "_occ"}, {30'd0, a_occupancy}, {30'd0, occ});
    check_eq({tag, "_rdy"}, {31'd0, a_in_ready}, {31'd0, rdy});
  endtask

  task automatic check_b(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [1:0] occ, input logic rdy);
    check_eq({tag, "_valid"}, {31'd0, b_out_valid}, {31'd0, v});
    check_eq({tag, "_pc"}, b_out_pc, pc);
    check_eq({tag, "_instr"}, b_out_instr, ins);
    check_eq({tag, "_occ"}, {30'd0, b_occupancy}, {30'd0, occ});
    check_eq({tag, "_rdy"}, {31'd0, b_in_ready}, {31'd0, rdy});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    a_in_valid = v;
    a_in_pc    = pc;
    a_in_instr = ins;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    b_in_valid = v;
    b_in_pc    = pc;
    b_in_instr = ins;
  endtask

  // Continuous invariants: no in_ready while the skid stage is full; single-entry stage never exceeds one beat.
  always @(negedge clk) begin
    if (rst) begin
      if (a_occupancy == 2'd2) check_eq("a_rdy_in_two", {31'd0, a_in_ready}, 32'd0);
      check_eq("b_occ_max", {31'd0, (b_occupancy <= 2'd1)}, 32'd1);
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    a_flush = 1'b0; a_out_ready = 1'b1; drive_a(1'b0, 32'h0, 32'h0);
    b_flush = 1'b0; b_out_ready = 1'b1; drive_b(1'b0, 32'h0, 32'h0);
    #2 rst = 1'b0;
    #1;
    check_a("a_rst", 1'b0, 32'h0, NOP, 2'd0, 1'b1);
    check_b("b_rst", 1'b0, 32'h0, NOP, 2'd0, 1'b1);

    // in_valid during reset must not be captured
    drive_a(1'b1, 32'hDEAD, 32'hBEEF);
    step();
    check_a("a_rst_hold", 1'b0, 32'h0, NOP, 2'd0, 1'b1);
    drive_a(1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    step();
    check_a("a_rel", 1'b0, 32'h0, NOP, 2'd0, 1'b1);
    check_b("b_rel", 1'b0, 32'h0, NOP, 2'd0, 1'b1);

    // Streaming at full rate
    drive_a(1'b1, 32'h100, 32'hA1); step(); check_a("str0", 1'b1, 32'h100, 32'hA1, 2'd1, 1'b1);
    drive_a(1'b1, 32'h104, 32'hA2); step(); check_a("str1", 1'b1, 32'h104, 32'hA2, 2'd1, 1'b1);
    drive_a(1'b1, 32'h108, 32'hA3); step(); check_a("str2", 1'b1, 32'h108, 32'hA3, 2'd1, 1'b1);
    drive_a(1'b0, 32'h0, 32'h0);    step(); check_a("str_drain", 1'b0, 32'h0, NOP, 2'd0, 1'b1);

    // Stall fills the skid entry, then drains in order
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h100, 32'hA1); step(); check_a("stl0", 1'b1, 32'h100, 32'hA1, 2'd1, 1'b1);
    drive_a(1'b1, 32'h104, 32'hA2); step(); check_a("stl1", 1'b1, 32'h100, 32'hA1, 2'd2, 1'b0);
    drive_a(1'b1, 32'h108, 32'hA3); step(); check_a("stl2", 1'b1, 32'h100, 32'hA1, 2'd2, 1'b0);
    a_out_ready = 1'b1;
    step(); check_a("stl3", 1'b1, 32'h104, 32'hA2, 2'd1, 1'b1);
    step(); check_a("stl4", 1'b1, 32'h108, 32'hA3, 2'd1, 1'b1);
    drive_a(1'b0, 32'h0, 32'h0);
    step(); check_a("stl_drain", 1'b0, 32'h0, NOP, 2'd0, 1'b1);

    // Flush from TWO with a beat waiting upstream
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h200, 32'hB0); step(); check_a("fl0", 1'b1, 32'h200, 32'hB0, 2'd1, 1'b1);
    drive_a(1'b1, 32'h204, 32'hB1); step(); check_a("fl1", 1'b1, 32'h200, 32'hB0, 2'd2, 1'b0);
    drive_a(1'b1, 32'h208, 32'hB2); a_flush = 1'b1;
    step(); check_a("fl2", 1'b0, 32'h0, NOP, 2'd0, 1'b1);
    a_flush = 1'b0; a_out_ready = 1'b1;
    drive_a(1'b1, 32'h20C, 32'hBC); step(); check_a("fl3", 1'b1, 32'h20C, 32'hBC, 2'd1, 1'b1);
    // Flush while a beat is accepted in the same cycle discards it
    drive_a(1'b1, 32'h210, 32'hB3); a_flush = 1'b1;
    step(); check_a("fl4", 1'b0, 32'h0, NOP, 2'd0, 1'b1);
    drive_a(1'b0, 32'h0, 32'h0); a_flush = 1'b0;
    step(); check_a("fl5", 1'b0, 32'h0, NOP, 2'd0, 1'b1);
    a_flush = 1'b1;
    step(); check_a("fl_empty", 1'b0, 32'h0, NOP, 2'd0, 1'b1);
    a_flush = 1'b0;

    // Asynchronous reset in TWO with a beat on the input
    a_out_ready = 1'b0;
    drive_a(1'b1, 32'h300, 32'hC0); step();
    drive_a(1'b1, 32'h304, 32'hC1); step(); check_a("mrst_pre", 1'b1, 32'h300, 32'hC0, 2'd2, 1'b0);
    drive_a(1'b1, 32'h308, 32'hC2);
    rst = 1'b0;
    #1; check_a("mrst_now", 1'b0, 32'h0, NOP, 2'd0, 1'b1);
    step();
    drive_a(1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    step(); check_a("mrst_rel", 1'b0, 32'h0, NOP, 2'd0, 1'b1);
    a_out_ready = 1'b1;

    // Single-entry build: combinational in_ready and reload without a bubble
    drive_b(1'b1, 32'h400, 32'hD0); step(); check_b("ns0", 1'b1, 32'h400, 32'hD0, 2'd1, 1'b1);
    b_out_ready = 1'b0;
    drive_b(1'b1, 32'h404, 32'hD1);
    #1; check_eq("ns_rdy_low", {31'd0, b_in_ready}, 32'd0);
    step(); check_b("ns1", 1'b1, 32'h400, 32'hD0, 2'd1, 1'b0);
    b_out_ready = 1'b1;
    #1; check_eq("ns_rdy_high", {31'd0, b_in_ready}, 32'd1);
    step(); check_b("ns2", 1'b1, 32'h404, 32'hD1, 2'd1, 1'b1);
    drive_b(1'b0, 32'h0, 32'h0);
    step(); check_b("ns_drain", 1'b0, 32'h0, NOP, 2'd0, 1'b1);
    drive_b(1'b1, 32'h408, 32'hD2); b_flush = 1'b1;
    step(); check_b("ns_flush", 1'b0, 32'h0, NOP, 2'd0, 1'b1);
    drive_b(1'b0, 32'h0, 32'h0); b_flush = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
